ps2_key_decoder: RTL and testbench

PS/2 scan-code-set-2 decoder placed between the PS/2 byte receiver and the display/CPU-side consumers. Tracks make/break/extended prefixes and modifier state, suppresses typematic repeats, translates keys to ASCII with shift, caps-lock and ctrl handling, and queues key events in a parametrised FIFO behind a valid/ready handshake. It generalises the single-register keyboard display path to buffered, multi-modifier, extended-key operation.

---
 rtl/ps2_pkg.sv | 91 +++++++++
 rtl/sync_fifo.sv | 45 ++++
 rtl/ps2_key_decoder.sv | 208 ++++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared scan-code-set-2 constants, parser state, key event record and
// the scan-code to ASCII translation used by the keyboard decoder.
package ps2_pkg;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_ALT    = 8'h11;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_ENTER  = 8'h5A;

  typedef enum logic [1:0] {ST_IDLE, ST_EXT, ST_BRK, ST_EXT_BRK} parse_state_e;

  typedef struct packed {
    logic       brk;
    logic       ext;
    logic [3:0] mods;
    logic [7:0] code;
    logic [7:0] ascii;
  } key_event_t;

  // Keyboard status/ack bytes that carry no key information.
  function automatic logic is_ignored(input logic [7:0] b);
    return b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF, 8'hE1};
  endfunction

  function automatic logic [7:0] scan_to_ascii(input logic [7:0] code, input logic ext,
                                               input logic shift, input logic ctrl,
                                               input logic caps);
    logic [4:0] letter;
    logic [3:0] digit;
    logic       is_letter;
    logic       is_digit;
    logic [7:0] a;
    is_letter = 1'b1;
    letter    = 5'd0;
    case (code)
      8'h1C: letter = 5'd0;   8'h32: letter = 5'd1;   8'h21: letter = 5'd2;
      8'h23: letter = 5'd3;   8'h24: letter = 5'd4;   8'h2B: letter = 5'd5;
      8'h34: letter = 5'd6;   8'h33: letter = 5'd7;   8'h43: letter = 5'd8;
      8'h3B: letter = 5'd9;   8'h42: letter = 5'd10;  8'h4B: letter = 5'd11;
      8'h3A: letter = 5'd12;  8'h31: letter = 5'd13;  8'h44: letter = 5'd14;
      8'h4D: letter = 5'd15;  8'h15: letter = 5'd16;  8'h2D: letter = 5'd17;
      8'h1B: letter = 5'd18;  8'h2C: letter = 5'd19;  8'h3C: letter = 5'd20;
      8'h2A: letter = 5'd21;  8'h1D: letter = 5'd22;  8'h22: letter = 5'd23;
      8'h35: letter = 5'd24;  8'h1A: letter = 5'd25;
      default: is_letter = 1'b0;
    endcase
    is_digit = 1'b1;
    digit    = 4'd0;
    case (code)
      8'h45: digit = 4'd0;  8'h16: digit = 4'd1;  8'h1E: digit = 4'd2;
      8'h26: digit = 4'd3;  8'h25: digit = 4'd4;  8'h2E: digit = 4'd5;
      8'h36: digit = 4'd6;  8'h3D: digit = 4'd7;  8'h3E: digit = 4'd8;
      8'h46: digit = 4'd9;
      default: is_digit = 1'b0;
    endcase
    a = 8'h00;
    if (ext) begin
      a = (code == SC_ENTER) ? 8'h0D : 8'h00;
    end else if (is_letter) begin
      if (ctrl)               a = {3'b000, letter} + 8'h01;
      else if (shift ^ caps)  a = {3'b000, letter} + 8'h41;
      else                    a = {3'b000, letter} + 8'h61;
    end else if (is_digit) begin
      if (!shift) begin
        a = {4'h3, digit};
      end else begin
        case (digit)
          4'd0: a = 8'h29;  4'd1: a = 8'h21;  4'd2: a = 8'h40;  4'd3: a = 8'h23;
          4'd4: a = 8'h24;  4'd5: a = 8'h25;  4'd6: a = 8'h5E;  4'd7: a = 8'h26;
          4'd8: a = 8'h2A;  4'd9: a = 8'h28;
          default: a = 8'h00;
        endcase
      end
    end else begin
      case (code)
        8'h29: a = 8'h20;
        8'h5A: a = 8'h0D;
        8'h66: a = 8'h08;
        8'h0D: a = 8'h09;
        8'h76: a = 8'h1B;
        default: a = 8'h00;
      endcase
    end
    return a;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; pointers carry an extra wrap bit so full and empty
// are told apart without a separate occupancy counter.
module sync_fifo #(
  parameter int WIDTH = 22,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem [DEPTH];

  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + {{AW{1'b0}}, 1'b1} : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + {{AW{1'b0}}, 1'b1} : rd_ptr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Writing into the head slot while full is safe: that slot is being popped.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr_q[AW-1:0]];
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 key decoder: prefix parsing, modifier tracking, typematic
// suppression, ASCII translation and a buffered valid/ready event queue.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 8,
  parameter bit BREAK_EV   = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       ps2_data,
  input  logic             ps2_valid,
  input  logic             ev_ready,
  output logic             ev_valid,
  output logic [7:0]       ev_code,
  output logic [7:0]       ev_ascii,
  output logic             ev_ext,
  output logic             ev_break,
  output logic [3:0]       ev_mods,
  output logic             shift_flag,
  output logic             ctrl_flag,
  output logic             alt_flag,
  output logic             caps_lock,
  output logic [CNT_W-1:0] key_cnt,
  output logic             overflow
);
  parse_state_e     state_q, state_d;
  logic             key_seen, key_ext, key_brk;
  logic             lshift_q, lshift_d, rshift_q, rshift_d;
  logic             lctrl_q, lctrl_d, rctrl_q, rctrl_d;
  logic             lalt_q, lalt_d, ralt_q, ralt_d;
  logic             caps_q, caps_d, caps_down_q, caps_down_d;
  logic             held_vld_q, held_vld_d, held_ext_q, held_ext_d;
  logic [7:0]       held_code_q, held_code_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  key_event_t       last_q, last_d, ev_in, fifo_dout, head;
  logic             ev_gen, is_mod, held_match, push, pop, fifo_full, fifo_empty;
  logic             shift_now, ctrl_now, alt_now;

  assign shift_now = lshift_q | rshift_q;
  assign ctrl_now  = lctrl_q | rctrl_q;
  assign alt_now   = lalt_q | ralt_q;

  always_comb begin
    state_d  = state_q;
    key_seen = 1'b0;
    key_ext  = 1'b0;
    key_brk  = 1'b0;
    if (ps2_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (ps2_data == SC_EXT)       state_d = ST_EXT;
          else if (ps2_data == SC_BRK)  state_d = ST_BRK;
          else if (!is_ignored(ps2_data)) key_seen = 1'b1;
        end
        ST_EXT: begin
          if (ps2_data == SC_BRK) begin
            state_d = ST_EXT_BRK;
          end else begin
            key_seen = 1'b1;
            key_ext  = 1'b1;
            state_d  = ST_IDLE;
          end
        end
        ST_BRK: begin
          key_seen = 1'b1;
          key_brk  = 1'b1;
          state_d  = ST_IDLE;
        end
        ST_EXT_BRK: begin
          key_seen = 1'b1;
          key_ext  = 1'b1;
          key_brk  = 1'b1;
          state_d  = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    lshift_d    = lshift_q;
    rshift_d    = rshift_q;
    lctrl_d     = lctrl_q;
    rctrl_d     = rctrl_q;
    lalt_d      = lalt_q;
    ralt_d      = ralt_q;
    caps_d      = caps_q;
    caps_down_d = caps_down_q;
    held_vld_d  = held_vld_q;
    held_ext_d  = held_ext_q;
    held_code_d = held_code_q;
    ev_gen      = 1'b0;
    is_mod      = 1'b0;
    held_match  = held_vld_q && (held_ext_q == key_ext) && (held_code_q == ps2_data);
    // Event fields reflect modifier state before this byte takes effect.
    ev_in.brk   = key_brk;
    ev_in.ext   = key_ext;
    ev_in.mods  = {caps_q, alt_now, ctrl_now, shift_now};
    ev_in.code  = ps2_data;
    ev_in.ascii = scan_to_ascii(ps2_data, key_ext, shift_now, ctrl_now, caps_q);
    if (key_seen) begin
      case ({key_ext, ps2_data})
        {1'b0, SC_LSHIFT}: begin is_mod = 1'b1; lshift_d = !key_brk; end
        {1'b0, SC_RSHIFT}: begin is_mod = 1'b1; rshift_d = !key_brk; end
        {1'b0, SC_CTRL}:   begin is_mod = 1'b1; lctrl_d  = !key_brk; end
        {1'b1, SC_CTRL}:   begin is_mod = 1'b1; rctrl_d  = !key_brk; end
        {1'b0, SC_ALT}:    begin is_mod = 1'b1; lalt_d   = !key_brk; end
        {1'b1, SC_ALT}:    begin is_mod = 1'b1; ralt_d   = !key_brk; end
        {1'b1, SC_LSHIFT}: is_mod = 1'b1;
        {1'b0, SC_CAPS}: begin
          is_mod      = 1'b1;
          caps_down_d = !key_brk;
          if (!key_brk && !caps_down_q) caps_d = !caps_q;
        end
        default: is_mod = 1'b0;
      endcase
      if (!is_mod) begin
        if (key_brk) begin
          if (held_match) held_vld_d = 1'b0;
          ev_gen = BREAK_EV;
        end else if (!held_match) begin
          held_vld_d  = 1'b1;
          held_ext_d  = key_ext;
          held_code_d = ps2_data;
          ev_gen      = 1'b1;
        end
      end
    end
  end

  always_comb begin
    pop    = !fifo_empty && ev_ready;
    push   = ev_gen && (!fifo_full || pop);
    ovf_d  = ovf_q | (ev_gen & !push);
    cnt_d  = cnt_q;
    if (push && !key_brk) cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    last_d = pop ? fifo_dout : last_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      lshift_q    <= 1'b0;
      rshift_q    <= 1'b0;
      lctrl_q     <= 1'b0;
      rctrl_q     <= 1'b0;
      lalt_q      <= 1'b0;
      ralt_q      <= 1'b0;
      caps_q      <= 1'b0;
      caps_down_q <= 1'b0;
      held_vld_q  <= 1'b0;
      held_ext_q  <= 1'b0;
      held_code_q <= 8'h00;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      last_q      <= '0;
    end else begin
      state_q     <= state_d;
      lshift_q    <= lshift_d;
      rshift_q    <= rshift_d;
      lctrl_q     <= lctrl_d;
      rctrl_q     <= rctrl_d;
      lalt_q      <= lalt_d;
      ralt_q      <= ralt_d;
      caps_q      <= caps_d;
      caps_down_q <= caps_down_d;
      held_vld_q  <= held_vld_d;
      held_ext_q  <= held_ext_d;
      held_code_q <= held_code_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      last_q      <= last_d;
    end
  end

  sync_fifo #(
    .WIDTH($bits(key_event_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr_en (push),
    .din   (ev_in),
    .rd_en (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // The last popped event stays visible on the payload while the queue is empty.
  assign head       = fifo_empty ? last_q : fifo_dout;
  assign ev_valid   = !fifo_empty;
  assign ev_code    = head.code;
  assign ev_ascii   = head.ascii;
  assign ev_ext     = head.ext;
  assign ev_break   = head.brk;
  assign ev_mods    = head.mods;
  assign shift_flag = shift_now;
  assign ctrl_flag  = ctrl_now;
  assign alt_flag   = alt_now;
  assign caps_lock  = caps_q;
  assign key_cnt    = cnt_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: directed scenarios plus randomized typing,
// with a queue-based reference model and an independent output monitor.
module tb_ps2_key_decoder;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] ps2_data;
  logic       ps2_valid;
  logic       ev_ready;
  logic       ev_valid;
  logic [7:0] ev_code, ev_ascii;
  logic       ev_ext, ev_break;
  logic [3:0] ev_mods;
  logic       shift_flag, ctrl_flag, alt_flag, caps_lock;
  logic [7:0] key_cnt;
  logic       overflow;

  always #5 clk = ~clk;

  ps2_key_decoder #(.FIFO_DEPTH(DEPTH), .CNT_W(8), .BREAK_EV(1'b0)) dut (
    .clk(clk), .rst(rst), .ps2_data(ps2_data), .ps2_valid(ps2_valid), .ev_ready(ev_ready),
    .ev_valid(ev_valid), .ev_code(ev_code), .ev_ascii(ev_ascii), .ev_ext(ev_ext),
    .ev_break(ev_break), .ev_mods(ev_mods), .shift_flag(shift_flag), .ctrl_flag(ctrl_flag),
    .alt_flag(alt_flag), .caps_lock(caps_lock), .key_cnt(key_cnt), .overflow(overflow)
  );

  typedef logic [21:0] ev_t;   // {break, ext, mods[3:0], code, ascii}
  ev_t q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  rdy_mode = 0;           // 0: hold off, 1: always accept, 2: random

  bit  pend_e0, pend_f0, m_caps, m_ovf;
  bit  pressed [512];
  int  held, m_cnt;

  logic [7:0] letter_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digit_sc [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] shsym [10]    = '{8'h29, 8'h21, 8'h40, 8'h23, 8'h24, 8'h25, 8'h5E, 8'h26, 8'h2A, 8'h28};
  logic [7:0] misc_sc [5]   = '{8'h29, 8'h5A, 8'h66, 8'h0D, 8'h76};
  logic [7:0] misc_as [5]   = '{8'h20, 8'h0D, 8'h08, 8'h09, 8'h1B};
  logic [7:0] ext_sc [4]    = '{8'h75, 8'h6B, 8'h5A, 8'h71};
  bit         mod_ext [8]   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [7:0] mod_sc [8]    = '{8'h12, 8'h59, 8'h14, 8'h14, 8'h11, 8'h11, 8'h58, 8'h12};

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_ascii(input logic [7:0] c, input bit ext, input bit sh,
                                           input bit ct, input bit cp);
    if (ext) return (c == 8'h5A) ? 8'h0D : 8'h00;
    for (int i = 0; i < 26; i++)
      if (c == letter_sc[i]) return ct ? 8'(i + 1) : 8'(((sh ^ cp) ? 65 : 97) + i);
    for (int i = 0; i < 10; i++)
      if (c == digit_sc[i]) return sh ? shsym[i] : 8'(48 + i);
    for (int i = 0; i < 5; i++)
      if (c == misc_sc[i]) return misc_as[i];
    return 8'h00;
  endfunction

  function automatic logic [3:0] m_mods();
    return {m_caps, pressed['h011] | pressed['h111], pressed['h014] | pressed['h114],
            pressed['h012] | pressed['h059]};
  endfunction

  function automatic void model_reset();
    q.delete();
    pend_e0 = 0; pend_f0 = 0; m_caps = 0; m_ovf = 0; held = -1; m_cnt = 0;
    for (int i = 0; i < 512; i++) pressed[i] = 0;
  endfunction

  function automatic void model_key(input bit ext, input bit brk, input logic [7:0] c);
    int k;
    logic [3:0] md;
    k  = (ext ? 256 : 0) + int'(c);
    md = m_mods();
    if (k inside {'h012, 'h059, 'h014, 'h114, 'h011, 'h111, 'h058, 'h112}) begin
      if (k == 'h058 && !brk && !pressed[k]) m_caps = !m_caps;
      pressed[k] = !brk;
      return;
    end
    if (brk) begin
      if (held == k) held = -1;
      return;
    end
    if (held == k) return;
    held = k;
    if (q.size() < DEPTH || (ev_ready && q.size() > 0)) begin
      q.push_back({1'b0, ext, md, c, ref_ascii(c, ext, md[0], md[1], md[3])});
      m_cnt++;
    end else begin
      m_ovf = 1;
    end
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    if (!pend_e0 && !pend_f0 && (b inside {8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF, 8'hE1})) return;
    if (!pend_e0 && !pend_f0 && b == 8'hE0) begin pend_e0 = 1; return; end
    if (!pend_f0 && b == 8'hF0) begin pend_f0 = 1; return; end
    model_key(pend_e0, pend_f0, b);
    pend_e0 = 0;
    pend_f0 = 0;
  endfunction

  task automatic tick(input logic v, input logic [7:0] b);
    @(negedge clk);
    #1;
    case (rdy_mode)
      0:       ev_ready = 1'b0;
      1:       ev_ready = 1'b1;
      default: ev_ready = ($urandom_range(0, 3) != 0);
    endcase
    ps2_valid = v;
    ps2_data  = b;
    if (v) model_byte(b);
  endtask

  task automatic send_key(input bit ext, input bit brk, input logic [7:0] c);
    if (ext) tick(1'b1, 8'hE0);
    if (brk) tick(1'b1, 8'hF0);
    tick(1'b1, c);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst = 1'b1; ps2_valid = 1'b0; ev_ready = 1'b0; rdy_mode = 0;
    model_reset();
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_live(input string nm);
    cmp({nm, "_mods"}, 32'({caps_lock, alt_flag, ctrl_flag, shift_flag}), 32'(m_mods()));
    cmp({nm, "_cnt"}, 32'(key_cnt), 32'(m_cnt % 256));
    cmp({nm, "_ovf"}, 32'(overflow), 32'(m_ovf));
  endtask

  task automatic peek(input string nm, input ev_t exp);
    cmp({nm, "_valid"}, 32'(ev_valid), 32'(1));
    cmp({nm, "_head"}, 32'({ev_break, ev_ext, ev_mods, ev_code, ev_ascii}), 32'(exp));
  endtask

  task automatic drain(input string nm);
    rdy_mode = 1;
    for (int i = 0; i < 4 * DEPTH + 8; i++) begin
      tick(1'b0, 8'h00);
      if (q.size() == 0 && !ev_valid) break;
    end
    rdy_mode = 0;
    tick(1'b0, 8'h00);
    cmp({nm, "_q_empty"}, 32'(q.size()), 32'(0));
    cmp({nm, "_valid_low"}, 32'(ev_valid), 32'(0));
  endtask

  // Monitor: compares every accepted event against the scoreboard head.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && ev_valid && ev_ready) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL mon_unexpected: got code 0x%0h, expected no event", ev_code);
        end else begin
          e = q.pop_front();
          cmp("mon_event", 32'({ev_break, ev_ext, ev_mods, ev_code, ev_ascii}), 32'(e));
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1);
  end

  initial begin
    ps2_data = 8'h00; ps2_valid = 1'b0; ev_ready = 1'b0;
    model_reset();
    do_reset();
    cmp("rst_valid", 32'(ev_valid), 32'(0));
    cmp("rst_payload", 32'({ev_break, ev_ext, ev_mods, ev_code, ev_ascii}), 32'(0));
    cmp("rst_flags", 32'({caps_lock, alt_flag, ctrl_flag, shift_flag}), 32'(0));
    cmp("rst_cnt", 32'(key_cnt), 32'(0));
    cmp("rst_ovf", 32'(overflow), 32'(0));

    // plain make, then release (no break event queued)
    send_key(0, 0, 8'h1C); send_key(0, 1, 8'h1C); tick(1'b0, 8'h00);
    peek("t1", {1'b0, 1'b0, 4'b0000, 8'h1C, 8'h61});
    cmp("t1_cnt", 32'(key_cnt), 32'(1));
    drain("t1");

    // shift held, typematic repeats suppressed
    do_reset();
    send_key(0, 0, 8'h12); tick(1'b0, 8'h00);
    cmp("t2_shift_on", 32'(shift_flag), 32'(1));
    send_key(0, 0, 8'h1C); send_key(0, 0, 8'h1C); send_key(0, 0, 8'h1C);
    send_key(0, 1, 8'h1C); send_key(0, 1, 8'h12); tick(1'b0, 8'h00);
    peek("t2", {1'b0, 1'b0, 4'b0001, 8'h1C, 8'h41});
    cmp("t2_shift_off", 32'(shift_flag), 32'(0));
    cmp("t2_cnt", 32'(key_cnt), 32'(1));
    drain("t2");

    // caps lock toggle with shift
    do_reset();
    send_key(0, 0, 8'h58); send_key(0, 1, 8'h58); send_key(0, 0, 8'h12); send_key(0, 0, 8'h1C);
    tick(1'b0, 8'h00);
    cmp("t3_caps_on", 32'(caps_lock), 32'(1));
    peek("t3", {1'b0, 1'b0, 4'b1001, 8'h1C, 8'h61});
    drain("t3");
    send_key(0, 1, 8'h1C); send_key(0, 1, 8'h12); send_key(0, 0, 8'h58); tick(1'b0, 8'h00);
    cmp("t3_caps_off", 32'(caps_lock), 32'(0));
    check_live("t3");

    // right ctrl + letter, extended key, ignored status bytes
    do_reset();
    send_key(1, 0, 8'h14); send_key(0, 0, 8'h21); tick(1'b0, 8'h00);
    cmp("t4_ctrl", 32'(ctrl_flag), 32'(1));
    peek("t4_ctrl_c", {1'b0, 1'b0, 4'b0010, 8'h21, 8'h03});
    drain("t4a");
    send_key(1, 1, 8'h14); send_key(1, 0, 8'h75); send_key(1, 1, 8'h75);
    tick(1'b1, 8'hAA); tick(1'b1, 8'hFA); tick(1'b0, 8'h00);
    peek("t4_ext", {1'b0, 1'b1, 4'b0000, 8'h75, 8'h00});
    cmp("t4_cnt", 32'(key_cnt), 32'(2));
    drain("t4b");

    // overflow on a full FIFO, then in-order drain
    do_reset();
    for (int i = 0; i < 9; i++) send_key(0, 0, letter_sc[i]);
    tick(1'b0, 8'h00);
    cmp("t5_ovf", 32'(overflow), 32'(1));
    cmp("t5_cnt", 32'(key_cnt), 32'(8));
    peek("t5", {1'b0, 1'b0, 4'b0000, 8'h1C, 8'h61});
    drain("t5");

    // full FIFO with a pop in the same cycle accepts the new event
    do_reset();
    for (int i = 0; i < 8; i++) send_key(0, 0, letter_sc[i]);
    rdy_mode = 1;
    send_key(0, 0, letter_sc[8]);
    rdy_mode = 0;
    tick(1'b0, 8'h00);
    cmp("t6_ovf", 32'(overflow), 32'(0));
    cmp("t6_cnt", 32'(key_cnt), 32'(9));
    tick(1'b1, 8'hE0);
    do_reset();
    cmp("t6_rst_valid", 32'(ev_valid), 32'(0));
    send_key(0, 0, 8'h1C); tick(1'b0, 8'h00);
    peek("t6_after_rst", {1'b0, 1'b0, 4'b0000, 8'h1C, 8'h61});
    cmp("t6_rst_cnt", 32'(key_cnt), 32'(1));
    drain("t6");

    // randomized typing with random consumer back-pressure
    do_reset();
    rdy_mode = 2;
    for (int it = 0; it < 250; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 2) begin
        int m;
        m = $urandom_range(0, 7);
        send_key(mod_ext[m], $urandom_range(0, 1) == 1, mod_sc[m]);
      end else if (r == 2) begin
        tick(1'b1, ($urandom_range(0, 1) == 1) ? 8'hAA : 8'hFA);
      end else begin
        bit ext;
        logic [7:0] c;
        int sel, reps;
        ext = ($urandom_range(0, 4) == 0);
        if (ext) begin
          c = ext_sc[$urandom_range(0, 3)];
        end else begin
          sel = $urandom_range(0, 42);
          if (sel < 26)      c = letter_sc[sel];
          else if (sel < 36) c = digit_sc[sel - 26];
          else if (sel < 41) c = misc_sc[sel - 36];
          else if (sel == 41) c = 8'h05;
          else               c = 8'h4E;
        end
        reps = $urandom_range(1, 3);
        for (int j = 0; j < reps; j++) send_key(ext, 0, c);
        if ($urandom_range(0, 3) != 0) send_key(ext, 1, c);
      end
      tick(1'b0, 8'h00);
      if (it % 10 == 0) check_live("rnd");
    end
    drain("rnd");
    check_live("rnd_end");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
